// File: rtl/cnn_layer_scheduler_pkg.sv
// Shared definitions for the CNN layer scheduler: FSM states, descriptor
// field layout, error codes and the registered per-layer configuration.
package cnn_layer_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_NEXT   = 3'd5
    } state_t;

    // word0 (config) field positions; bits [1:0] are reserved
    localparam int DESC_CONV_BIT  = 2;
    localparam int DESC_ACT_BIT   = 3;
    localparam int DESC_IDX_LSB   = 4;
    localparam int DESC_BIAS_LSB  = 8;
    localparam int DESC_ASH_LSB   = 13;
    // word1 (base addresses) field positions
    localparam int DESC_WBASE_LSB = 0;
    localparam int DESC_PBASE_LSB = 20;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_NUM = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef struct packed {
        logic        is_first;
        logic        is_last;
        logic        conv3x3;
        logic        act_type;
        logic [3:0]  layer_index;
        logic [4:0]  bias_shift;
        logic [2:0]  act_shift;
        logic [19:0] base_weight;
        logic [11:0] base_param;
    } layer_cfg_t;

endpackage

// File: rtl/cnn_layer_scheduler_desc_ram.sv
// Descriptor store: 2*N_LAYER x 32 register file, synchronous write,
// combinational read of both words of one layer. Contents are not reset.
module cnn_desc_ram #(
    parameter int N_LAYER = 3,
    parameter int W_LAYER = 2
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [W_LAYER:0]   i_waddr,
    input  logic [31:0]        i_wdata,
    input  logic [W_LAYER-1:0] i_rlayer,
    output logic [31:0]        o_word0,
    output logic [31:0]        o_word1
);

    localparam int DEPTH = 2 * N_LAYER;

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we && (int'(i_waddr) < DEPTH)) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_word0 = mem_q[{i_rlayer, 1'b0}];
    assign o_word1 = mem_q[{i_rlayer, 1'b1}];

endmodule

// File: rtl/cnn_layer_scheduler.sv
// Walks the preloaded layer descriptors, presenting each layer's config to
// the frame FSM, pulsing start and waiting for its end-of-frame.
module cnn_layer_scheduler
    import cnn_layer_scheduler_pkg::*;
#(
    parameter int N_LAYER       = 3,
    parameter int W_LAYER       = (N_LAYER > 1) ? $clog2(N_LAYER) : 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int WDT_CYCLES    = 0,
    parameter int W_WDT         = 24
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_desc_we,
    input  logic [W_LAYER:0]   i_desc_addr,
    input  logic [31:0]        i_desc_wdata,
    input  logic [4:0]         i_num_layers,
    input  logic               i_run,
    input  logic               i_abort,
    input  logic               i_layer_done,
    output logic               o_layer_start,
    output logic               o_is_first_layer,
    output logic               o_is_last_layer,
    output logic               o_is_conv3x3,
    output logic               o_act_type,
    output logic [3:0]         o_layer_index,
    output logic [4:0]         o_bias_shift,
    output logic [2:0]         o_act_shift,
    output logic [19:0]        o_base_addr_weight,
    output logic [11:0]        o_base_addr_param,
    output logic [W_LAYER-1:0] o_cur_layer,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_err,
    output logic [2:0]         o_dbg_state
);

    // Control protocol: i_run, i_abort and i_layer_done are single-cycle
    // pulses sampled on the rising edge; there is no back-pressure. i_run is
    // only accepted in IDLE, i_layer_done only in WAIT, i_abort only outside
    // IDLE. o_layer_start is a one-cycle pulse with config already stable.

    localparam int               W_SET       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [W_SET-1:0] SETTLE_LAST = W_SET'(SETTLE_CYCLES - 1);
    localparam logic             WDT_EN      = (WDT_CYCLES != 0);
    // The START cycle and the first WAIT edge account for two of the budget.
    localparam logic [W_WDT-1:0] WDT_LIMIT   = W_WDT'((WDT_CYCLES >= 2) ? WDT_CYCLES - 2 : 0);
    localparam logic [4:0]       NUM_MAX     = 5'(N_LAYER);

    state_t             state_q, state_d;
    logic [W_LAYER-1:0] ptr_q, ptr_d;
    logic [W_LAYER-1:0] num_m1_q, num_m1_d;
    logic [W_SET-1:0]   settle_q, settle_d;
    logic [W_WDT-1:0]   wdt_q, wdt_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;
    layer_cfg_t         cfg_q, cfg_d;

    logic [31:0]        desc_word0;
    logic [31:0]        desc_word1;
    logic               run_ok;
    logic               desc_unused;

    cnn_desc_ram #(
        .N_LAYER (N_LAYER),
        .W_LAYER (W_LAYER)
    ) u_desc_ram (
        .clk      (clk),
        .i_we     (i_desc_we),
        .i_waddr  (i_desc_addr),
        .i_wdata  (i_desc_wdata),
        .i_rlayer (ptr_q),
        .o_word0  (desc_word0),
        .o_word1  (desc_word1)
    );

    assign desc_unused = ^{desc_word0[31:16], desc_word0[1:0]};
    assign run_ok      = (i_num_layers != 5'd0) && (i_num_layers <= NUM_MAX);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        num_m1_d = num_m1_q;
        settle_d = settle_q;
        wdt_d    = wdt_q;
        start_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        cfg_d    = cfg_q;

        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    done_d = 1'b0;
                    if (run_ok) begin
                        ptr_d    = '0;
                        num_m1_d = W_LAYER'(i_num_layers - 5'd1);
                        err_d    = ERR_NONE;
                        busy_d   = 1'b1;
                        state_d  = S_LOAD;
                    end else begin
                        err_d = ERR_BAD_NUM;
                    end
                end
            end
            S_LOAD: begin
                cfg_d.is_first    = (ptr_q == '0);
                cfg_d.is_last     = (ptr_q == num_m1_q);
                cfg_d.conv3x3     = desc_word0[DESC_CONV_BIT];
                cfg_d.act_type    = desc_word0[DESC_ACT_BIT];
                cfg_d.layer_index = desc_word0[DESC_IDX_LSB +: 4];
                cfg_d.bias_shift  = desc_word0[DESC_BIAS_LSB +: 5];
                cfg_d.act_shift   = desc_word0[DESC_ASH_LSB +: 3];
                cfg_d.base_weight = desc_word1[DESC_WBASE_LSB +: 20];
                cfg_d.base_param  = desc_word1[DESC_PBASE_LSB +: 12];
                settle_d          = '0;
                state_d           = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    start_d = 1'b1;
                    state_d = S_START;
                end else begin
                    settle_d = settle_q + W_SET'(1);
                end
            end
            S_START: begin
                wdt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_layer_done) begin
                    state_d = S_NEXT;
                end else if (WDT_EN && (wdt_q == WDT_LIMIT)) begin
                    err_d   = ERR_TIMEOUT;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    wdt_d = wdt_q + W_WDT'(1);
                end
            end
            S_NEXT: begin
                if (ptr_q == num_m1_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    ptr_d   = ptr_q + W_LAYER'(1);
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever the state logic decided this cycle.
        if (i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            start_d = 1'b0;
            busy_d  = 1'b0;
            err_d   = ERR_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            num_m1_q <= '0;
            settle_q <= '0;
            wdt_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= ERR_NONE;
            cfg_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            num_m1_q <= num_m1_d;
            settle_q <= settle_d;
            wdt_q    <= wdt_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cfg_q    <= cfg_d;
        end
    end

    assign o_layer_start      = start_q;
    assign o_is_first_layer   = cfg_q.is_first;
    assign o_is_last_layer    = cfg_q.is_last;
    assign o_is_conv3x3       = cfg_q.conv3x3;
    assign o_act_type         = cfg_q.act_type;
    assign o_layer_index      = cfg_q.layer_index;
    assign o_bias_shift       = cfg_q.bias_shift;
    assign o_act_shift        = cfg_q.act_shift;
    assign o_base_addr_weight = cfg_q.base_weight;
    assign o_base_addr_param  = cfg_q.base_param;
    assign o_cur_layer        = ptr_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_err              = err_q;
    assign o_dbg_state        = state_q;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Directed bench for cnn_layer_scheduler: a cycle-timeline model of the
// layer sequence is compared against the DUT every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_cnn_layer_scheduler;

    localparam int N_LAYER = 3;
    localparam int SETTLE  = 2;
    localparam int WDT     = 100;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic        i_desc_we = 1'b0;
    logic [2:0]  i_desc_addr = '0;
    logic [31:0] i_desc_wdata = '0;
    logic [4:0]  i_num_layers = '0;
    logic        i_run = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_layer_done = 1'b0;

    logic        o_layer_start, o_is_first_layer, o_is_last_layer, o_is_conv3x3, o_act_type;
    logic [3:0]  o_layer_index;
    logic [4:0]  o_bias_shift;
    logic [2:0]  o_act_shift;
    logic [19:0] o_base_addr_weight;
    logic [11:0] o_base_addr_param;
    logic [1:0]  o_cur_layer;
    logic        o_busy, o_done;
    logic [1:0]  o_err;
    logic [2:0]  o_dbg_state;

    cnn_layer_scheduler #(
        .N_LAYER       (N_LAYER),
        .SETTLE_CYCLES (SETTLE),
        .WDT_CYCLES    (WDT),
        .W_WDT         (24)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .i_desc_we          (i_desc_we),
        .i_desc_addr        (i_desc_addr),
        .i_desc_wdata       (i_desc_wdata),
        .i_num_layers       (i_num_layers),
        .i_run              (i_run),
        .i_abort            (i_abort),
        .i_layer_done       (i_layer_done),
        .o_layer_start      (o_layer_start),
        .o_is_first_layer   (o_is_first_layer),
        .o_is_last_layer    (o_is_last_layer),
        .o_is_conv3x3       (o_is_conv3x3),
        .o_act_type         (o_act_type),
        .o_layer_index      (o_layer_index),
        .o_bias_shift       (o_bias_shift),
        .o_act_shift        (o_act_shift),
        .o_base_addr_weight (o_base_addr_weight),
        .o_base_addr_param  (o_base_addr_param),
        .o_cur_layer        (o_cur_layer),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_err              (o_err),
        .o_dbg_state        (o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // Timeline view: a run edge E loads at E+1 and starts at E+1+SETTLE; a done
    // edge D loads at D+2; the final done edge completes the run at D+1.
    logic [31:0] desc_m [2*N_LAYER];
    int m_busy = 0, m_done = 0, m_err = 0, m_layer = 0, m_num = 0;
    bit pend_load = 0, pend_start = 0, pend_finish = 0, waiting = 0;
    int load_due = 0, start_due = 0, finish_due = 0, start_at = -1;
    logic [31:0] m_w0 = '0, m_w1 = '0;
    int m_first = 0, m_last = 0;

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            cyc = 0; m_busy = 0; m_done = 0; m_err = 0; m_layer = 0; m_num = 0;
            pend_load = 0; pend_start = 0; pend_finish = 0; waiting = 0; start_at = -1;
            m_w0 = '0; m_w1 = '0; m_first = 0; m_last = 0;
        end else begin
            cyc = cyc + 1;
            if (m_busy != 0 && i_abort) begin
                m_busy = 0; m_err = 3;
                pend_load = 0; pend_start = 0; pend_finish = 0; waiting = 0;
            end else if (m_busy == 0 && i_run) begin
                m_done = 0;
                if (i_num_layers >= 1 && i_num_layers <= N_LAYER) begin
                    m_busy = 1; m_err = 0; m_layer = 0; m_num = i_num_layers;
                    pend_load = 1; load_due = cyc + 1;
                    pend_start = 1; start_due = cyc + 1 + SETTLE;
                end else begin
                    m_err = 1;
                end
            end else if (m_busy != 0) begin
                if (waiting && cyc >= start_at + 2 && i_layer_done) begin
                    waiting = 0;
                    if (m_layer == m_num - 1) begin
                        pend_finish = 1; finish_due = cyc + 1;
                    end else begin
                        m_layer = m_layer + 1;
                        pend_load = 1; load_due = cyc + 2;
                        pend_start = 1; start_due = cyc + 2 + SETTLE;
                    end
                end else if (waiting && cyc == start_at + WDT) begin
                    waiting = 0; m_busy = 0; m_err = 2;
                end
            end
            if (pend_load && cyc == load_due) begin
                pend_load = 0;
                m_w0 = desc_m[2*m_layer];
                m_w1 = desc_m[2*m_layer+1];
                m_first = (m_layer == 0);
                m_last  = (m_layer == m_num - 1);
            end
            if (pend_start && cyc == start_due) begin
                pend_start = 0; waiting = 1; start_at = cyc;
            end
            if (pend_finish && cyc == finish_due) begin
                pend_finish = 0; m_busy = 0; m_done = 1;
            end
            if (i_desc_we) desc_m[i_desc_addr] = i_desc_wdata;
        end
    end

    // Compare process: every cycle, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        chk("start", o_layer_start, (start_at == cyc) ? 1 : 0);
        chk("busy",  o_busy, m_busy);
        chk("done",  o_done, m_done);
        chk("err",   o_err,  m_err);
        chk("first", o_is_first_layer, m_first);
        chk("last",  o_is_last_layer,  m_last);
        chk("conv",  o_is_conv3x3, (m_w0 >> 2) & 1);
        chk("act",   o_act_type,   (m_w0 >> 3) & 1);
        chk("index", o_layer_index, (m_w0 >> 4) & 15);
        chk("bias_shift", o_bias_shift, (m_w0 >> 8) & 31);
        chk("act_shift",  o_act_shift,  (m_w0 >> 13) & 7);
        chk("wbase", o_base_addr_weight, m_w1 & 32'h000F_FFFF);
        chk("pbase", o_base_addr_param, (m_w1 >> 20) & 32'h0000_0FFF);
        if (start_at == cyc) chk("cur_layer", o_cur_layer, m_layer);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic delay(input int n);
        repeat (n) tick();
    endtask

    task automatic write_desc(input int addr, input logic [31:0] data);
        i_desc_we = 1'b1; i_desc_addr = 3'(addr); i_desc_wdata = data;
        tick();
        i_desc_we = 1'b0;
    endtask

    task automatic pulse_run(input int num);
        i_num_layers = 5'(num); i_run = 1'b1;
        tick();
        i_run = 1'b0;
    endtask

    task automatic pulse_done();
        i_layer_done = 1'b1;
        tick();
        i_layer_done = 1'b0;
    endtask

    task automatic pulse_abort();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
    endtask

    task automatic wait_start(input string name, output int at);
        bit ok = 0;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            if (o_layer_start) begin ok = 1; at = cyc; break; end
            tick();
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_finish(input string name);
        bit ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_done) begin ok = 1; break; end
            tick();
        end
        chk(name, ok, 1);
    endtask

    // ---------------- directed stimulus ----------------
    int e, s, d, seen;

    initial begin
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk("rst_busy", o_busy, 0);
        chk("rst_err",  o_err, 0);
        chk("rst_cur",  o_cur_layer, 0);
        chk("rst_wbase", o_base_addr_weight, 0);

        write_desc(0, 32'h0000_A5F4); write_desc(1, 32'h1234_5678);
        write_desc(2, 32'h0000_0014); write_desc(3, 32'h0010_0100);
        write_desc(4, 32'h0000_1228); write_desc(5, 32'h2020_0200);

        // three-layer pass, run-to-start latency, literal field decode
        pulse_run(3);
        e = cyc;
        wait_start("t1_start0", s);
        chk("t1_run_latency", s - e, 3);
        chk("t2_conv", o_is_conv3x3, 1);
        chk("t2_act", o_act_type, 0);
        chk("t2_index", o_layer_index, 4'hF);
        chk("t2_bias", o_bias_shift, 5);
        chk("t2_ashift", o_act_shift, 5);
        chk("t2_wbase", o_base_addr_weight, 20'h45678);
        chk("t2_pbase", o_base_addr_param, 12'h123);
        chk("t1_first0", o_is_first_layer, 1);
        chk("t1_last0", o_is_last_layer, 0);
        pulse_done();          // lands in START: ignored
        pulse_run(1);          // busy: ignored
        delay(3);
        pulse_done();
        d = cyc;
        wait_start("t1_start1", s);
        chk("t1_done_latency", s - d, 4);
        chk("t1_first1", o_is_first_layer, 0);
        chk("t1_last1", o_is_last_layer, 0);
        chk("t1_cur1", o_cur_layer, 1);
        delay(2);
        pulse_done();
        wait_start("t1_start2", s);
        chk("t1_last2", o_is_last_layer, 1);
        chk("t1_cur2", o_cur_layer, 2);
        delay(2);
        pulse_done();
        chk("t1_done_early", o_done, 0);
        tick();
        chk("t1_done", o_done, 1);
        chk("t1_busy_end", o_busy, 0);

        // bad layer counts
        delay(2);
        pulse_run(0);
        chk("t3_err0", o_err, 1);
        chk("t3_busy0", o_busy, 0);
        chk("t3_done_cleared", o_done, 0);
        delay(5);
        pulse_run(4);
        chk("t3_err4", o_err, 1);
        delay(5);

        // watchdog timeout
        pulse_run(1);
        chk("t4_err_cleared", o_err, 0);
        wait_start("t4_start", s);
        delay(99);
        chk("t4_err_before", o_err, 0);
        chk("t4_busy_before", o_busy, 1);
        tick();
        chk("t4_err_timeout", o_err, 2);
        chk("t4_busy_after", o_busy, 0);
        delay(3);

        // abort together with done in WAIT
        pulse_run(3);
        chk("t5_err_cleared", o_err, 0);
        wait_start("t5_start", s);
        delay(3);
        i_layer_done = 1'b1; i_abort = 1'b1;
        tick();
        i_layer_done = 1'b0; i_abort = 1'b0;
        chk("t5_err_abort", o_err, 3);
        chk("t5_busy", o_busy, 0);
        seen = 0;
        repeat (20) begin
            tick();
            if (o_layer_start) seen++;
        end
        chk("t5_no_start", seen, 0);
        pulse_abort();         // IDLE: no effect
        chk("t5_idle_abort", o_err, 3);

        // rewrite layer 1 while layer 0 runs, then reset inside WAIT
        pulse_run(3);
        wait_start("t6_start0", s);
        write_desc(2, 32'h0000_3B28);
        write_desc(3, 32'hABCD_E012);
        delay(2);
        pulse_done();
        wait_start("t6_start1", s);
        chk("t6_conv", o_is_conv3x3, 0);
        chk("t6_act", o_act_type, 1);
        chk("t6_index", o_layer_index, 2);
        chk("t6_bias", o_bias_shift, 27);
        chk("t6_ashift", o_act_shift, 1);
        chk("t6_wbase", o_base_addr_weight, 20'hDE012);
        chk("t6_pbase", o_base_addr_param, 12'hABC);
        delay(3);
        rstn = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_cur", o_cur_layer, 0);
        chk("t6_rst_index", o_layer_index, 0);
        chk("t6_rst_wbase", o_base_addr_weight, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // descriptors survive reset
        delay(2);
        pulse_run(2);
        wait_start("t7_start0", s);
        delay(2);
        pulse_done();
        wait_start("t7_start1", s);
        chk("t7_wbase", o_base_addr_weight, 20'hDE012);
        chk("t7_last", o_is_last_layer, 1);
        delay(2);
        pulse_done();
        wait_finish("t7_done");
        delay(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
